// File: rtl/fp_align_pkg.sv
// Shared types and field helpers for the FP operand-alignment pipeline.
// Helpers work on a wide container so any EXP_W/MAN_W up to 63 total bits fits.
package fp_align_pkg;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        NAN
    } fp_class_t;

    localparam int unsigned DEF_EXP_W = 8;
    localparam int unsigned DEF_MAN_W = 23;
    localparam int unsigned SIG_W     = DEF_MAN_W + 4;
    localparam int unsigned MAX_W     = 64;

    typedef logic [MAX_W-1:0] fp_wide_t;

    function automatic fp_wide_t fp_field_exp(input fp_wide_t op, input int unsigned exp_w,
                                              input int unsigned man_w);
        fp_wide_t mask;
        mask = (fp_wide_t'(1) << exp_w) - fp_wide_t'(1);
        return (op >> man_w) & mask;
    endfunction

    function automatic fp_wide_t fp_field_man(input fp_wide_t op, input int unsigned man_w);
        fp_wide_t mask;
        mask = (fp_wide_t'(1) << man_w) - fp_wide_t'(1);
        return op & mask;
    endfunction

    function automatic logic fp_field_sign(input fp_wide_t op, input int unsigned exp_w,
                                           input int unsigned man_w);
        return |((op >> (exp_w + man_w)) & fp_wide_t'(1));
    endfunction

    function automatic fp_class_t fp_classify(input fp_wide_t exp, input fp_wide_t man,
                                              input int unsigned exp_w);
        fp_wide_t ones;
        ones = (fp_wide_t'(1) << exp_w) - fp_wide_t'(1);
        if (exp == '0) begin
            return (man == '0) ? ZERO : SUB;
        end else if (exp == ones) begin
            return (man == '0) ? INF : NAN;
        end
        return NORM;
    endfunction

endpackage

// File: rtl/fp_align_pipe_shift_sticky.sv
// Right shifter with sticky collapse; shifts of SIG_W or more clamp to a lone sticky bit.
module fp_shift_sticky #(
    parameter int unsigned SIG_W = 27,
    parameter int unsigned SH_W  = 8
) (
    input  logic [SIG_W-1:0] i_sig,
    input  logic [SH_W-1:0]  i_sh,
    output logic [SIG_W-1:0] o_sig
);

    logic             w_clamp;
    logic             w_lost;
    logic [SIG_W-1:0] w_shifted;
    logic [SIG_W-1:0] w_lost_mask;

    assign w_clamp     = 32'(i_sh) >= SIG_W;
    assign w_shifted   = i_sig >> i_sh;
    assign w_lost_mask = ~({SIG_W{1'b1}} << i_sh);
    // Incoming S bit is either kept in place (shift 0) or folded in via w_lost.
    assign w_lost      = |(i_sig & w_lost_mask);

    always_comb begin
        o_sig = w_shifted;
        if (w_clamp) begin
            o_sig = {{(SIG_W-1){1'b0}}, |i_sig};
        end else begin
            o_sig = {w_shifted[SIG_W-1:1], w_shifted[0] | w_lost};
        end
    end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage FP adder operand alignment: stage 1 classifies and orders by magnitude,
// stage 2 shifts the smaller significand with guard/round/sticky. Valid/ready throughout.
module fp_align_pipe
    import fp_align_pkg::*;
#(
    parameter int unsigned EXP_W = DEF_EXP_W,
    parameter int unsigned MAN_W = DEF_MAN_W,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W-1:0]         out_exp,
    output logic [MAN_W+3:0]         out_man_big,
    output logic [MAN_W+3:0]         out_man_small,
    output logic                     out_sign_big,
    output logic                     out_sign_small,
    output logic                     out_swapped,
    output logic                     out_eff_sub,
    output logic                     out_bypass,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int unsigned SW    = MAN_W + 4;
    localparam int unsigned KEY_W = EXP_W + 1 + MAN_W;

    logic [EXP_W-1:0] w_a_exp, w_b_exp, w_a_eff_exp, w_b_eff_exp;
    logic [MAN_W-1:0] w_a_man, w_b_man;
    logic             w_a_sign, w_b_sign;
    fp_class_t        w_a_cls, w_b_cls;
    logic [KEY_W-1:0] w_a_key, w_b_key, w_big_key, w_small_key;
    logic             w_b_big;
    logic [EXP_W-1:0] w_diff;
    logic             w_bypass;
    logic             w_s1_adv, w_s2_adv;
    logic [SW-1:0]    w_s2_small;

    logic             r_s1_valid;
    logic [EXP_W-1:0] r_s1_exp;
    logic [EXP_W-1:0] r_s1_diff;
    logic [SW-1:0]    r_s1_sig_big;
    logic [SW-1:0]    r_s1_sig_small;
    logic             r_s1_sign_big, r_s1_sign_small;
    logic             r_s1_swapped, r_s1_eff_sub, r_s1_bypass;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_out_valid;
    logic [EXP_W-1:0] r_out_exp;
    logic [SW-1:0]    r_out_man_big, r_out_man_small;
    logic             r_out_sign_big, r_out_sign_small;
    logic             r_out_swapped, r_out_eff_sub, r_out_bypass;
    logic [TAG_W-1:0] r_out_tag;

    assign w_a_exp  = EXP_W'(fp_field_exp(fp_wide_t'(in_a), EXP_W, MAN_W));
    assign w_b_exp  = EXP_W'(fp_field_exp(fp_wide_t'(in_b), EXP_W, MAN_W));
    assign w_a_man  = MAN_W'(fp_field_man(fp_wide_t'(in_a), MAN_W));
    assign w_b_man  = MAN_W'(fp_field_man(fp_wide_t'(in_b), MAN_W));
    assign w_a_sign = fp_field_sign(fp_wide_t'(in_a), EXP_W, MAN_W);
    assign w_b_sign = fp_field_sign(fp_wide_t'(in_b), EXP_W, MAN_W);
    assign w_a_cls  = fp_classify(fp_wide_t'(w_a_exp), fp_wide_t'(w_a_man), EXP_W);
    assign w_b_cls  = fp_classify(fp_wide_t'(w_b_exp), fp_wide_t'(w_b_man), EXP_W);

    // Subnormals sit at effective exponent 1 with no hidden bit.
    assign w_a_eff_exp = (w_a_cls == SUB) ? EXP_W'(1) : w_a_exp;
    assign w_b_eff_exp = (w_b_cls == SUB) ? EXP_W'(1) : w_b_exp;
    assign w_a_key     = {w_a_eff_exp, (w_a_exp != '0), w_a_man};
    assign w_b_key     = {w_b_eff_exp, (w_b_exp != '0), w_b_man};

    assign w_b_big     = w_b_key > w_a_key;
    assign w_big_key   = w_b_big ? w_b_key : w_a_key;
    assign w_small_key = w_b_big ? w_a_key : w_b_key;
    assign w_diff      = w_big_key[KEY_W-1 -: EXP_W] - w_small_key[KEY_W-1 -: EXP_W];
    assign w_bypass    = (w_a_cls inside {ZERO, INF, NAN}) || (w_b_cls inside {ZERO, INF, NAN});

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid      <= 1'b0;
            r_s1_exp        <= '0;
            r_s1_diff       <= '0;
            r_s1_sig_big    <= '0;
            r_s1_sig_small  <= '0;
            r_s1_sign_big   <= 1'b0;
            r_s1_sign_small <= 1'b0;
            r_s1_swapped    <= 1'b0;
            r_s1_eff_sub    <= 1'b0;
            r_s1_bypass     <= 1'b0;
            r_s1_tag        <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_exp        <= w_big_key[KEY_W-1 -: EXP_W];
                r_s1_diff       <= w_diff;
                r_s1_sig_big    <= {w_big_key[MAN_W:0], 3'b000};
                r_s1_sig_small  <= {w_small_key[MAN_W:0], 3'b000};
                r_s1_sign_big   <= w_b_big ? w_b_sign : w_a_sign;
                r_s1_sign_small <= w_b_big ? w_a_sign : w_b_sign;
                r_s1_swapped    <= w_b_big;
                r_s1_eff_sub    <= w_a_sign ^ w_b_sign;
                r_s1_bypass     <= w_bypass;
                r_s1_tag        <= in_tag;
            end
        end
    end

    fp_shift_sticky #(
        .SIG_W (SW),
        .SH_W  (EXP_W)
    ) u_shift_sticky (
        .i_sig (r_s1_sig_small),
        .i_sh  (r_s1_diff),
        .o_sig (w_s2_small)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_out_exp        <= '0;
            r_out_man_big    <= '0;
            r_out_man_small  <= '0;
            r_out_sign_big   <= 1'b0;
            r_out_sign_small <= 1'b0;
            r_out_swapped    <= 1'b0;
            r_out_eff_sub    <= 1'b0;
            r_out_bypass     <= 1'b0;
            r_out_tag        <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_exp        <= r_s1_exp;
                r_out_man_big    <= r_s1_sig_big;
                r_out_man_small  <= w_s2_small;
                r_out_sign_big   <= r_s1_sign_big;
                r_out_sign_small <= r_s1_sign_small;
                r_out_swapped    <= r_s1_swapped;
                r_out_eff_sub    <= r_s1_eff_sub;
                r_out_bypass     <= r_s1_bypass;
                r_out_tag        <= r_s1_tag;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_exp        = r_out_exp;
    assign out_man_big    = r_out_man_big;
    assign out_man_small  = r_out_man_small;
    assign out_sign_big   = r_out_sign_big;
    assign out_sign_small = r_out_sign_small;
    assign out_swapped    = r_out_swapped;
    assign out_eff_sub    = r_out_eff_sub;
    assign out_bypass     = r_out_bypass;
    assign out_tag        = r_out_tag;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed bench for fp_align_pipe at single precision: alignment vectors, specials,
// throughput, back-pressure and mid-stream reset.
module tb_fp_align_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exp;
    logic [26:0] out_man_big, out_man_small;
    logic        out_sign_big, out_sign_small, out_swapped, out_eff_sub, out_bypass;
    logic [3:0]  out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [61:0] vdata [6];
    logic [4:0]  vflags [6];

    fp_align_pipe #(
        .EXP_W (8),
        .MAN_W (23),
        .TAG_W (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_exp        (out_exp),
        .out_man_big    (out_man_big),
        .out_man_small  (out_man_small),
        .out_sign_big   (out_sign_big),
        .out_sign_small (out_sign_small),
        .out_swapped    (out_swapped),
        .out_eff_sub    (out_eff_sub),
        .out_bypass     (out_bypass),
        .out_tag        (out_tag)
    );

    always #5 clk = ~clk;

    // Launches one op into an empty pipe and returns the cycles until out_valid (bounded).
    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                           output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 8);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_handshake got valid=%b ready=%b want valid=0 ready=1",
                     out_valid, in_ready);
        end
        n_tests++;
        if ({out_exp, out_man_big, out_man_small, out_tag, out_sign_big, out_sign_small,
             out_swapped, out_eff_sub, out_bypass} !== 71'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got exp=%h big=%h small=%h tag=%h want all zero",
                     out_exp, out_man_big, out_man_small, out_tag);
        end
        reset = 1'b0;
    endtask

    task automatic test_align_vectors();
        int lat;
        // {exp, man_big, man_small}; flags {sign_big, sign_small, swapped, eff_sub, bypass}
        va     = '{32'h3F800000, 32'h3F800000, 32'h4B800000, 32'h7F000000, 32'h00000001,
                   32'hBF800000};
        vb     = '{32'h3F800000, 32'h40000000, 32'h3F800001, 32'h3F800000, 32'h00000003,
                   32'h3F800000};
        vdata  = '{{8'h7F, 27'h4000000, 27'h4000000}, {8'h80, 27'h4000000, 27'h2000000},
                   {8'h97, 27'h4000000, 27'h0000005}, {8'hFE, 27'h4000000, 27'h0000001},
                   {8'h01, 27'h0000018, 27'h0000008}, {8'h7F, 27'h4000000, 27'h4000000}};
        vflags = '{5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b10010};
        for (int i = 0; i < 6; i++) begin
            send_op(va[i], vb[i], 4'(i + 1), lat);
            n_tests++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL align%0d_latency got %0d want 2", i, lat);
            end
            n_tests++;
            if ({out_exp, out_man_big, out_man_small} !== vdata[i]) begin
                n_fail++;
                $display("FAIL align%0d_data got exp=%h big=%h small=%h want %h", i,
                         out_exp, out_man_big, out_man_small, vdata[i]);
            end
            n_tests++;
            if ({out_sign_big, out_sign_small, out_swapped, out_eff_sub, out_bypass} !== vflags[i]
                || out_tag !== 4'(i + 1)) begin
                n_fail++;
                $display("FAIL align%0d_flags got flags=%b tag=%h want flags=%b tag=%h", i,
                         {out_sign_big, out_sign_small, out_swapped, out_eff_sub, out_bypass},
                         out_tag, vflags[i], 4'(i + 1));
            end
        end
    endtask

    task automatic test_special();
        int lat;
        send_op(32'h7FC00000, 32'h3F800000, 4'h7, lat);
        n_tests++;
        if ({out_exp, out_man_big, out_man_small, out_swapped, out_bypass} !==
            {8'hFF, 27'h6000000, 27'h0000001, 1'b0, 1'b1} || lat !== 2) begin
            n_fail++;
            $display("FAIL special_nan got exp=%h big=%h small=%h sw=%b byp=%b lat=%0d want FF 6000000 0000001 0 1 2",
                     out_exp, out_man_big, out_man_small, out_swapped, out_bypass, lat);
        end
        send_op(32'h00000000, 32'h3F800000, 4'h8, lat);
        n_tests++;
        if ({out_exp, out_man_big, out_man_small, out_swapped, out_bypass} !==
            {8'h7F, 27'h4000000, 27'h0000000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL special_zero got exp=%h big=%h small=%h sw=%b byp=%b want 7F 4000000 0 1 1",
                     out_exp, out_man_big, out_man_small, out_swapped, out_bypass);
        end
        send_op(32'h3F800000, 32'hFF800000, 4'h9, lat);
        n_tests++;
        if ({out_exp, out_man_small, out_sign_big, out_sign_small, out_swapped, out_eff_sub,
             out_bypass} !== {8'hFF, 27'h0000001, 5'b10111}) begin
            n_fail++;
            $display("FAIL special_inf got exp=%h small=%h flags=%b want FF 0000001 10111",
                     out_exp, out_man_small,
                     {out_sign_big, out_sign_small, out_swapped, out_eff_sub, out_bypass});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vpat;
        logic [3:0] tags [8];
        logic [7:0] exps [8];
        int         rdy_cnt;
        rdy_cnt   = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            vpat[cyc] = out_valid;
            tags[cyc] = out_tag;
            exps[cyc] = out_exp;
            if (cyc < 4) begin
                in_valid = 1'b1;
                in_a     = 32'h3F800000 + (32'(cyc) << 23);
                in_b     = 32'h3F800000;
                in_tag   = 4'(cyc + 1);
                if (in_ready) rdy_cnt++;
            end else begin
                in_valid = 1'b0;
            end
        end
        n_tests++;
        if (vpat !== 8'b0011_1100 || rdy_cnt !== 4) begin
            n_fail++;
            $display("FAIL b2b_valid_pattern got %b ready=%0d want 00111100 ready=4", vpat, rdy_cnt);
        end
        n_tests++;
        if ({tags[2], tags[3], tags[4], tags[5]} !== 16'h1234) begin
            n_fail++;
            $display("FAIL b2b_tags got %h%h%h%h want 1234", tags[2], tags[3], tags[4], tags[5]);
        end
        n_tests++;
        if ({exps[2], exps[3], exps[4], exps[5]} !== 32'h7F808182) begin
            n_fail++;
            $display("FAIL b2b_exps got %h%h%h%h want 7F808182", exps[2], exps[3], exps[4], exps[5]);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] pa [3];
        logic [31:0] pb [3];
        logic [3:0]  got_tag [3];
        logic [7:0]  got_exp [3];
        logic [26:0] got_small [3];
        int          accepted;
        int          got_n;
        logic        rdy;
        pa = '{32'h3F800000, 32'h4B800000, 32'h7F000000};
        pb = '{32'h40000000, 32'h3F800001, 32'h3F800000};
        accepted  = 0;
        got_n     = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (cyc >= 2) begin
                n_tests++;
                if ({out_valid, out_tag, out_exp, out_man_small} !==
                    {1'b1, 4'hA, 8'h80, 27'h2000000}) begin
                    n_fail++;
                    $display("FAIL bp_hold_c%0d got v=%b tag=%h exp=%h small=%h want 1 A 80 2000000",
                             cyc, out_valid, out_tag, out_exp, out_man_small);
                end
            end
            if (accepted < 3) begin
                in_valid = 1'b1;
                in_a     = pa[accepted];
                in_b     = pb[accepted];
                in_tag   = 4'(4'hA + accepted);
            end else begin
                in_valid = 1'b0;
            end
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) accepted++;
        end
        @(negedge clk);
        n_tests++;
        if (accepted !== 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_refuse_third got accepted=%0d ready=%b want 2 0", accepted, in_ready);
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (out_valid && got_n < 3) begin
                got_tag[got_n]   = out_tag;
                got_exp[got_n]   = out_exp;
                got_small[got_n] = out_man_small;
                got_n++;
            end
            if (accepted < 3) begin
                in_valid = 1'b1;
                in_a     = pa[accepted];
                in_b     = pb[accepted];
                in_tag   = 4'(4'hA + accepted);
            end else begin
                in_valid = 1'b0;
            end
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) accepted++;
        end
        n_tests++;
        if (got_n !== 3 || accepted !== 3) begin
            n_fail++;
            $display("FAIL bp_drain_count got results=%0d accepted=%0d want 3 3", got_n, accepted);
        end else begin
            n_tests++;
            if ({got_tag[0], got_tag[1], got_tag[2]} !== 12'hABC) begin
                n_fail++;
                $display("FAIL bp_order_tags got %h%h%h want ABC", got_tag[0], got_tag[1], got_tag[2]);
            end
            n_tests++;
            if ({got_exp[0], got_exp[1], got_exp[2], got_small[0], got_small[1], got_small[2]} !==
                {8'h80, 8'h97, 8'hFE, 27'h2000000, 27'h0000005, 27'h0000001}) begin
                n_fail++;
                $display("FAIL bp_order_data got exps=%h %h %h smalls=%h %h %h want 80 97 FE 2000000 5 1",
                         got_exp[0], got_exp[1], got_exp[2], got_small[0], got_small[1], got_small[2]);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        int seen;
        seen      = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 32'h3F800000;
            in_b     = 32'h40000000;
            in_tag   = 4'(4'h5 + cyc);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_flush got %0d stale results want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_align_vectors();
        test_special();
        test_back_to_back();
        test_back_pressure();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Parametrised, two-stage pipelined operand-alignment unit for the FP adder datapath; sits between operand unpack and the add/normalise stage.
- Orders operands by magnitude, computes the exponent difference and right-shifts the smaller significand.
- Produces guard/round/sticky bits and flags special operands for ALU bypass.
- Adds a valid/ready handshake, configurable formats, clamped long shifts and a passthrough tag.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa field width.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  stage 1 can accept.
- in_a  in  1+EXP_W+MAN_W  operand A, packed sign/exponent/mantissa.
- in_b  in  1+EXP_W+MAN_W  operand B, packed.
- in_tag  in  TAG_W  sideband ID, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_exp  out  EXP_W  common (larger effective) exponent.
- out_man_big  out  MAN_W+4  {hidden, mantissa, G, R, S} of the larger operand; GRS = 000.
- out_man_small  out  MAN_W+4  shifted smaller operand with GRS; S is the OR of all bits shifted out.
- out_sign_big  out  1  sign of the larger operand.
- out_sign_small  out  1  sign of the smaller operand.
- out_swapped  out  1  B was the larger operand.
- out_eff_sub  out  1  signs differ.
- out_bypass  out  1  either operand is NaN, Inf or zero.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
- On reset, every stage valid bit and every output register clears to 0; in_ready is 1 in the cycle after reset.
- Reset mid-operation discards all in-flight items.
- Latency is exactly 2 cycles from input handshake (in_valid & in_ready) to out_valid, with no stall. Throughput is 1 per cycle.
- Handshake:
  - A transfer occurs when valid & ready.
  - Stage 2 advances when !s2_valid | out_ready. Stage 1 advances when !s1_valid | s2 advances. in_ready equals the stage-1 advance condition; it is combinational back-pressure, with no skid buffer.
  - While out_valid is high and out_ready is low, all out_* fields hold stable.
  - Two items may be held under stall; a third is refused with in_ready = 0.
- Stage 1 (classify and compare):
  - Classify each operand as ZERO, SUB, NORM, INF or NAN.
  - Subnormal operands use effective exponent 1 and hidden bit 0; normal operands use the field exponent and hidden bit 1.
  - Magnitude compare on {eff_exp, hidden, mantissa}. B is larger if strictly greater, so ties give swapped = 0.
  - diff = eff_exp_big - eff_exp_small, unsigned EXP_W bits.
  - Register: the big/small significands with 000 appended, diff, signs, swapped, eff_sub, bypass and tag.
- Stage 2 (shift and sticky):
  - If diff >= MAN_W+4, out_man_small = {0..0, S}, where S = |small_significand.
  - Otherwise shift right by diff; S = original S | OR of all bits shifted past bit 0.
  - out_exp = eff_exp_big.
- Bypass: out_bypass = 1 if either operand is ZERO, INF or NAN. In that case the datapath still computes per the rules above; downstream selects the special result.
- Simultaneous in and out handshakes in the same cycle with a full pipe are legal and keep full throughput.

Decomposition:
- Package fp_align_pkg holds:
  - fp_class_t enum: ZERO, SUB, NORM, INF, NAN.
  - Field-extract functions, parametrised by EXP_W and MAN_W.
  - The classify function.
  - Localparam SIG_W = MAN_W+4.
- One sub-module, fp_shift_sticky: parametrised right shifter with sticky collapse and clamp, instantiated in stage 2.

Test Plan (defaults, single precision):
- Equal exponents, A=3F800000, B=3F800000:
  - After 2 cycles: out_exp=7F, man_big=man_small=27'h4000000, swapped=0, S=0.
- Small diff, A=3F800000, B=40000000:
  - out_exp=80, swapped=1, man_big=27'h4000000, man_small=27'h2000000, S=0.
- Sticky, A=4B800000, B=3F800001 (diff 24):
  - man_small=27'h0000005 (G=1, S=1), out_exp=97.
- Clamp, A=7F000000, B=3F800000 (diff 127):
  - man_small=27'h0000001, out_exp=FE.
- Subnormals, A=00000001, B=00000003:
  - out_exp=01, man_big=27'h0000018, man_small=27'h0000008, swapped=1, bypass=0.
- Special and back-pressure:
  - A=7FC00000 (NaN) with any B gives bypass=1.
  - Stream 3 ops with out_ready=0 for 4 cycles: in_ready drops after 2 accepted, outputs hold stable, all 3 results emerge in order with tags intact.
  - Asserting reset mid-stream gives out_valid=0 next cycle.
